dds_sweep_ctrl: RTL and testbench
=================================

DDS_SWEEP_CTRL -- requirements
Module: dds_sweep_ctrl

Interface
REQ-001 The block SHALL have parameter FREQ_W, default 32, setting the tuning-word width and matching the DDS FreqCntrl width.
REQ-002 The block SHALL have parameter DWELL_W, default 32, setting the dwell-counter width.
REQ-003 Port AXI_clk  in  1  is the single clock; all logic SHALL be clocked on its rising edge.
REQ-004 Port rst  in  1  is the reset; it SHALL be synchronous and active-high.
REQ-005 Port Start  in  1  is a one-cycle request to latch the configuration and begin a sweep.
REQ-006 Port Abort  in  1  stops the sweep immediately.
REQ-007 Port Mode  in  2  selects the sweep shape: 00 single, 01 sawtooth repeat, 10 triangle repeat, 11 reserved and treated as 00.
REQ-008 Ports StartFreq, StopFreq, StepFreq  in  FREQ_W  are unsigned tuning words.
REQ-009 Port DwellCycles  in  DWELL_W  gives the number of cycles each frequency is held.
REQ-010 Port FreqCntrl  out  FREQ_W  drives the DDS tuning word directly.
REQ-011 Port FreqValid  out  1  SHALL pulse for one cycle whenever FreqCntrl changes value.
REQ-012 Ports Busy  out  1, Done  out  1 (one-cycle pulse) and CfgErr  out  1 (one-cycle pulse) report sweep status.

Function
REQ-013 The FSM states SHALL be IDLE, UP, DOWN and FINISH.
REQ-014 In IDLE, a Start with StartFreq < StopFreq and StepFreq != 0 SHALL cause the following at the same edge: latch all configuration inputs; load FreqCntrl with StartFreq; assert Busy; enter UP.
REQ-015 A Start with StartFreq >= StopFreq or StepFreq == 0 SHALL be ignored, SHALL leave FreqCntrl unchanged and SHALL pulse CfgErr for one cycle.
REQ-016 Each frequency SHALL be held for exactly max(DwellCycles,1) cycles, counted from the edge that loaded it.
REQ-017 Dwell expiry in UP, with FreqCntrl < StopFreq, SHALL set next = FreqCntrl + StepFreq, computed FREQ_W+1 bits wide and clamped to StopFreq when it exceeds StopFreq, so no wrap-around occurs.
REQ-018 Dwell expiry in UP, with FreqCntrl == StopFreq, SHALL act by mode:
- single: enter FINISH;
- sawtooth: reload StartFreq and stay in UP;
- triangle: enter DOWN with next = StopFreq - StepFreq, clamped to StartFreq.
REQ-019 Dwell expiry in DOWN SHALL act as follows:
- FreqCntrl > StartFreq: next = FreqCntrl - StepFreq, with underflow clamped to StartFreq;
- FreqCntrl == StartFreq: next = StartFreq + StepFreq (clamped) and enter UP.
REQ-020 FINISH SHALL last one cycle with Done=1, then enter IDLE with Busy=0; Busy SHALL fall on the edge that enters FINISH.
REQ-021 FreqCntrl SHALL hold its last value in IDLE and FINISH.
REQ-022 An Abort in any non-IDLE state SHALL return the FSM to IDLE on the next edge with Busy=0 and FreqCntrl held, and SHALL NOT pulse Done.
REQ-023 Abort and Start asserted in the same cycle SHALL resolve as Abort, with Start ignored.
REQ-024 A Start while Busy SHALL be ignored, with no CfgErr pulse.
REQ-025 Input changes while Busy SHALL have no effect until the next accepted Start.
REQ-026 FreqValid SHALL be registered and asserted in the cycle after each FreqCntrl update, including the initial load and a reload to the same value in sawtooth mode.

Reset
REQ-027 While rst=1, at the next edge the block SHALL set FSM=IDLE, FreqCntrl=0, FreqValid=0, Busy=0, Done=0, CfgErr=0, and clear the dwell counter and latched configuration.
REQ-028 A reset asserted mid-sweep SHALL override Start and Abort and SHALL produce no Done pulse.

Structure
REQ-029 Package dds_sweep_pkg SHALL hold the FSM state encoding and the mode constants MODE_SINGLE, MODE_SAW and MODE_TRI.
REQ-030 The dwell timer SHALL be a sub-module, sweep_dwell_cnt, with load, count and expire outputs; all other logic SHALL stay in dds_sweep_ctrl.

Verification
REQ-031 Single sweep: Start=100, Stop=130, Step=10, Dwell=4, Mode=00 -> FreqCntrl steps 100,110,120,130, each held 4 cycles; four FreqValid pulses; Done 16 cycles after the Start edge; Busy low thereafter; FreqCntrl stays at 130.
REQ-032 Clamp: Start=0, Stop=25, Step=10, Dwell=1, Mode=00 -> sequence 0,10,20,25 with no wrap; Done follows.
REQ-033 Triangle: Start=10, Stop=30, Step=10, Dwell=2, Mode=10 -> sequence 10,20,30,20,10,20,... until Abort; after Abort, Busy=0 next cycle, FreqCntrl held, no Done.
REQ-034 Sawtooth near full scale: Start=0xFFFFFFF0, Stop=0xFFFFFFFF, Step=0x10, Dwell=1, Mode=01 -> sequence F0, FF (clamped), F0, ...; FreqValid pulses on every reload.
REQ-035 Errors and priority:
- Start with Stop=Start -> single-cycle CfgErr pulse, Busy stays 0;
- Start and Abort in the same cycle from IDLE -> nothing happens;
- rst mid-sweep -> all outputs 0 next cycle.
REQ-036 Dwell zero: Dwell=0 -> each frequency held 1 cycle, identical to the Dwell=1 case.

Source files
------------

// File: rtl/dds_sweep_pkg.sv
// Shared constants for the DDS frequency-sweep controller: FSM state
// encoding and the sweep-shape mode codes.
package dds_sweep_pkg;

  // FSM state encoding
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_UP     = 2'd1;
  localparam logic [1:0] ST_DOWN   = 2'd2;
  localparam logic [1:0] ST_FINISH = 2'd3;

  // Sweep shapes; code 2'b11 is reserved and behaves as MODE_SINGLE
  localparam logic [1:0] MODE_SINGLE = 2'b00;
  localparam logic [1:0] MODE_SAW    = 2'b01;
  localparam logic [1:0] MODE_TRI    = 2'b10;

  // True while a frequency is actively being held and stepped
  function automatic logic is_sweeping(input logic [1:0] st);
    return (st == ST_UP) || (st == ST_DOWN);
  endfunction

endpackage

// File: rtl/sweep_dwell_cnt.sv
// Dwell timer: loaded whenever a new tuning word is applied, then counts
// down while enabled. expire is high during the last cycle of the dwell,
// so the next word lands exactly max(load_val,1) cycles after the load.
module sweep_dwell_cnt #(
  parameter int DWELL_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [DWELL_W-1:0] load_val,
  input  logic               count,
  output logic               expire
);

  localparam logic [DWELL_W-1:0] ONE = DWELL_W'(1);

  logic [DWELL_W-1:0] remain_q;

  // Remaining cycles after the current one; a dwell of 0 behaves as 1
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking (<=) so every flop samples
    // pre-edge values regardless of block ordering.
    if (rst) begin
      remain_q <= '0;
    end else if (load) begin
      remain_q <= (load_val == '0) ? '0 : load_val - ONE;
    end else if (count && (remain_q != '0)) begin
      remain_q <= remain_q - ONE;
    end
  end

  assign expire = (remain_q == '0);

endmodule

// File: rtl/dds_sweep_ctrl.sv
// DDS frequency-sweep controller. Latches a sweep configuration on Start,
// then steps the DDS tuning word between StartFreq and StopFreq in single,
// sawtooth or triangle shape, holding each word for a programmable dwell.
module dds_sweep_ctrl
  import dds_sweep_pkg::*;
#(
  parameter int FREQ_W  = 32,
  parameter int DWELL_W = 32
) (
  input  logic               AXI_clk,
  input  logic               rst,
  input  logic               Start,
  input  logic               Abort,
  input  logic [1:0]         Mode,
  input  logic [FREQ_W-1:0]  StartFreq,
  input  logic [FREQ_W-1:0]  StopFreq,
  input  logic [FREQ_W-1:0]  StepFreq,
  input  logic [DWELL_W-1:0] DwellCycles,
  output logic [FREQ_W-1:0]  FreqCntrl,
  output logic               FreqValid,
  output logic               Busy,
  output logic               Done,
  output logic               CfgErr
);

  logic [1:0]         state_q, state_d;
  logic [FREQ_W-1:0]  start_q, stop_q, step_q;
  logic [DWELL_W-1:0] dwell_q;
  logic [1:0]         mode_q;

  logic [FREQ_W-1:0]  freq_d;
  logic               freq_load;
  logic               cfg_ok;
  logic               start_take;
  logic               expire;
  logic [DWELL_W-1:0] dwell_sel;

  // Step arithmetic; additions are one bit wider so the clamp sees overflow
  logic [FREQ_W:0]    up_sum, rise_sum;
  logic [FREQ_W-1:0]  up_next, rise_next, down_next, fall_next;

  assign cfg_ok     = (StartFreq < StopFreq) && (StepFreq != '0);
  assign start_take = (state_q == ST_IDLE) && Start && !Abort && cfg_ok;

  // Next word going up from the current word, clamped to the stop word
  assign up_sum    = {1'b0, FreqCntrl} + {1'b0, step_q};
  assign up_next   = (up_sum > {1'b0, stop_q}) ? stop_q : up_sum[FREQ_W-1:0];
  // Turnaround at the bottom of a triangle: start + step, clamped
  assign rise_sum  = {1'b0, start_q} + {1'b0, step_q};
  assign rise_next = (rise_sum > {1'b0, stop_q}) ? stop_q : rise_sum[FREQ_W-1:0];
  // Next word going down, clamped to the start word instead of underflowing
  assign down_next = ((FreqCntrl - start_q) <= step_q) ? start_q : FreqCntrl - step_q;
  // Turnaround at the top of a triangle: stop - step, clamped
  assign fall_next = ((stop_q - start_q) <= step_q) ? start_q : stop_q - step_q;

  // The accepting Start uses the live dwell input; later loads use the latched one
  assign dwell_sel = (state_q == ST_IDLE) ? DwellCycles : dwell_q;

  sweep_dwell_cnt #(
    .DWELL_W (DWELL_W)
  ) u_dwell (
    .clk      (AXI_clk),
    .rst      (rst),
    .load     (freq_load),
    .load_val (dwell_sel),
    .count    (is_sweeping(state_q)),
    .expire   (expire)
  );

  // Next-state and next-tuning-word decision
  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // leaves a value unassigned and infers a latch.
    state_d   = state_q;
    freq_d    = FreqCntrl;
    freq_load = 1'b0;

    if (state_q == ST_IDLE) begin
      if (start_take) begin
        state_d   = ST_UP;
        freq_d    = StartFreq;
        freq_load = 1'b1;
      end
    end else if (Abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_UP: begin
          if (expire) begin
            if (FreqCntrl < stop_q) begin
              freq_d    = up_next;
              freq_load = 1'b1;
            end else begin
              case (mode_q)
                MODE_SAW: begin
                  freq_d    = start_q;
                  freq_load = 1'b1;
                end
                MODE_TRI: begin
                  state_d   = ST_DOWN;
                  freq_d    = fall_next;
                  freq_load = 1'b1;
                end
                default: state_d = ST_FINISH;
              endcase
            end
          end
        end
        ST_DOWN: begin
          if (expire) begin
            freq_load = 1'b1;
            if (FreqCntrl > start_q) begin
              freq_d = down_next;
            end else begin
              state_d = ST_UP;
              freq_d  = rise_next;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State, tuning word, status flags and latched configuration
  always_ff @(posedge AXI_clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      FreqCntrl <= '0;
      FreqValid <= 1'b0;
      Busy      <= 1'b0;
      Done      <= 1'b0;
      CfgErr    <= 1'b0;
      // NOTE: the configuration registers are cleared too, so a sweep
      // aborted by reset can never resume with a stale configuration.
      start_q   <= '0;
      stop_q    <= '0;
      step_q    <= '0;
      dwell_q   <= '0;
      mode_q    <= MODE_SINGLE;
    end else begin
      state_q   <= state_d;
      FreqValid <= freq_load;
      Busy      <= is_sweeping(state_d);
      Done      <= (state_d == ST_FINISH);
      CfgErr    <= (state_q == ST_IDLE) && Start && !Abort && !cfg_ok;
      if (freq_load) begin
        FreqCntrl <= freq_d;
      end
      if (start_take) begin
        start_q <= StartFreq;
        stop_q  <= StopFreq;
        step_q  <= StepFreq;
        dwell_q <= DwellCycles;
        mode_q  <= Mode;
      end
    end
  end

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Self-checking bench for dds_sweep_ctrl. The reference model expands a
// configuration into the list of tuning words one period of the sweep
// visits, then derives every cycle's expected outputs from the cycle
// index, the dwell length and that list.
module tb_dds_sweep_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic [31:0] start_freq = '0;
  logic [31:0] stop_freq = '0;
  logic [31:0] step_freq = '0;
  logic [31:0] dwell = '0;
  logic [31:0] freq_cntrl;
  logic        freq_valid, busy, done, cfg_err;

  always #5 clk = ~clk;

  dds_sweep_ctrl #(
    .FREQ_W  (32),
    .DWELL_W (32)
  ) dut (
    .AXI_clk     (clk),
    .rst         (rst),
    .Start       (start),
    .Abort       (abort),
    .Mode        (mode),
    .StartFreq   (start_freq),
    .StopFreq    (stop_freq),
    .StepFreq    (step_freq),
    .DwellCycles (dwell),
    .FreqCntrl   (freq_cntrl),
    .FreqValid   (freq_valid),
    .Busy        (busy),
    .Done        (done),
    .CfgErr      (cfg_err)
  );

  int          n_checks = 0;
  int          n_fail = 0;
  longint      seq[$];          // tuning words of one sweep period
  bit          single_m;
  int          dw_eff;
  logic [31:0] exp_freq = '0;   // word the DUT should be holding while idle

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Word list for one period: climb to stop, and for triangle come back
  // down to (but not including) start.
  function automatic void build_model(input longint s, input longint e,
                                      input longint st, input logic [1:0] m);
    longint v;
    seq.delete();
    v = s;
    seq.push_back(v);
    while (v < e) begin
      v = v + st;
      if (v > e) v = e;
      seq.push_back(v);
    end
    single_m = (m == 2'b00) || (m == 2'b11);
    if (m == 2'b10) begin
      v = e;
      while (v > s) begin
        v = v - st;
        if (v < s) v = s;
        if (v != s) seq.push_back(v);
      end
    end
  endfunction

  // Expected outputs k cycles after the accepting Start edge
  function automatic void expect_at(input int k, output logic [31:0] f,
                                    output logic v, output logic b, output logic d);
    int idx;
    int n;
    idx = k / dw_eff;
    n   = seq.size();
    if (single_m && idx >= n) begin
      f = 32'(seq[n-1]);
      v = 1'b0;
      b = 1'b0;
      d = (k == n * dw_eff);
    end else begin
      f = 32'(seq[single_m ? idx : idx % n]);
      v = ((k % dw_eff) == 0);
      b = 1'b1;
      d = 1'b0;
    end
  endfunction

  // One sweep from Start to idle. Repeating modes always end by Abort after
  // nrep cycles; single mode runs to Done unless do_abort. With junk set,
  // random Start pulses and configuration changes are applied while busy.
  task automatic run_sweep(input logic [31:0] s, input logic [31:0] e,
                           input logic [31:0] st, input logic [31:0] dw,
                           input logic [1:0] m, input int nrep,
                           input bit do_abort, input bit junk);
    int          ncyc, abort_at, n, lim;
    logic [31:0] f, held;
    logic        v, b, d;
    build_model(longint'(s), longint'(e), longint'(st), m);
    dw_eff = (dw == 0) ? 1 : int'(dw);
    n = seq.size();
    if (single_m) begin
      if (do_abort) begin
        abort_at = $urandom_range(1, n * dw_eff - 1);
        ncyc     = abort_at + 2;
      end else begin
        abort_at = -1;
        ncyc     = n * dw_eff + 2;
      end
      lim = n * dw_eff - 1;
      if (abort_at >= 0 && abort_at < lim) lim = abort_at;
    end else begin
      ncyc     = nrep;
      abort_at = nrep - 2;
      lim      = abort_at;
    end

    start_freq = s;
    stop_freq  = e;
    step_freq  = st;
    dwell      = dw;
    mode       = m;
    start      = 1'b1;
    step_cycle();
    start = 1'b0;
    held  = exp_freq;

    for (int k = 0; k <= ncyc; k++) begin
      if (abort_at >= 0 && k >= abort_at) begin
        f = held;
        v = 1'b0;
        b = 1'b0;
        d = 1'b0;
      end else begin
        expect_at(k, f, v, b, d);
        held = f;
      end
      check($sformatf("freq k=%0d", k), 64'(freq_cntrl), 64'(f));
      check($sformatf("valid k=%0d", k), 64'(freq_valid), 64'(v));
      check($sformatf("busy k=%0d", k), 64'(busy), 64'(b));
      check($sformatf("done k=%0d", k), 64'(done), 64'(d));
      check($sformatf("cfgerr k=%0d", k), 64'(cfg_err), 64'd0);

      abort = (k + 1 == abort_at);
      if (junk && k < lim) begin
        start      = ($urandom_range(0, 2) == 0);
        mode       = 2'($urandom_range(0, 3));
        start_freq = $urandom;
        stop_freq  = $urandom;
        step_freq  = $urandom_range(0, 50);
        dwell      = $urandom_range(0, 5);
      end else begin
        start = 1'b0;
      end
      step_cycle();
    end
    start    = 1'b0;
    abort    = 1'b0;
    exp_freq = held;
  endtask

  // A rejected configuration: one CfgErr pulse, nothing else moves
  task automatic bad_cfg(input string tag, input logic [31:0] s,
                         input logic [31:0] e, input logic [31:0] st);
    start_freq = s;
    stop_freq  = e;
    step_freq  = st;
    dwell      = 32'd3;
    mode       = 2'b00;
    start      = 1'b1;
    step_cycle();
    start = 1'b0;
    check({tag, " cfgerr"}, 64'(cfg_err), 64'd1);
    check({tag, " busy"}, 64'(busy), 64'd0);
    check({tag, " freq"}, 64'(freq_cntrl), 64'(exp_freq));
    check({tag, " valid"}, 64'(freq_valid), 64'd0);
    step_cycle();
    check({tag, " cfgerr one cycle"}, 64'(cfg_err), 64'd0);
    check({tag, " still idle"}, 64'(busy), 64'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] s, span, st;

    // Reset state
    step_cycle();
    step_cycle();
    check("rst freq", 64'(freq_cntrl), 64'd0);
    check("rst valid", 64'(freq_valid), 64'd0);
    check("rst busy", 64'(busy), 64'd0);
    check("rst done", 64'(done), 64'd0);
    check("rst cfgerr", 64'(cfg_err), 64'd0);
    rst = 1'b0;
    step_cycle();

    // Directed sweeps
    run_sweep(32'd100, 32'd130, 32'd10, 32'd4, 2'b00, 0, 1'b0, 1'b0);
    check("single final freq", 64'(freq_cntrl), 64'd130);
    run_sweep(32'd0, 32'd25, 32'd10, 32'd1, 2'b00, 0, 1'b0, 1'b0);
    check("clamp final freq", 64'(freq_cntrl), 64'd25);
    run_sweep(32'd10, 32'd30, 32'd10, 32'd2, 2'b10, 22, 1'b1, 1'b0);
    run_sweep(32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'h10, 32'd1, 2'b01, 12, 1'b1, 1'b0);
    run_sweep(32'd100, 32'd130, 32'd10, 32'd0, 2'b00, 0, 1'b0, 1'b0);
    run_sweep(32'd5, 32'd40, 32'd7, 32'd2, 2'b11, 0, 1'b0, 1'b1);

    // Error handling and priority
    bad_cfg("stop=start", 32'd50, 32'd50, 32'd5);
    bad_cfg("start>stop", 32'd60, 32'd50, 32'd5);
    bad_cfg("step=0", 32'd10, 32'd50, 32'd0);

    start_freq = 32'd10;
    stop_freq  = 32'd50;
    step_freq  = 32'd5;
    dwell      = 32'd1;
    mode       = 2'b01;
    start      = 1'b1;
    abort      = 1'b1;
    step_cycle();
    start = 1'b0;
    abort = 1'b0;
    check("start+abort busy", 64'(busy), 64'd0);
    check("start+abort cfgerr", 64'(cfg_err), 64'd0);
    check("start+abort valid", 64'(freq_valid), 64'd0);
    check("start+abort freq", 64'(freq_cntrl), 64'(exp_freq));
    step_cycle();
    check("start+abort stays idle", 64'(busy), 64'd0);

    // Reset in the middle of a sweep wins over Start and Abort
    start_freq = 32'd1000;
    stop_freq  = 32'd2000;
    step_freq  = 32'd100;
    dwell      = 32'd2;
    mode       = 2'b10;
    start      = 1'b1;
    step_cycle();
    start = 1'b0;
    repeat (5) step_cycle();
    rst   = 1'b1;
    start = 1'b1;
    abort = 1'b1;
    step_cycle();
    check("midrst freq", 64'(freq_cntrl), 64'd0);
    check("midrst valid", 64'(freq_valid), 64'd0);
    check("midrst busy", 64'(busy), 64'd0);
    check("midrst done", 64'(done), 64'd0);
    check("midrst cfgerr", 64'(cfg_err), 64'd0);
    rst   = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    exp_freq = '0;
    step_cycle();
    check("post rst idle", 64'(busy), 64'd0);
    check("post rst no done", 64'(done), 64'd0);

    // Randomized sweeps, sometimes near full scale, with noise while busy
    for (int t = 0; t < 24; t++) begin
      st   = $urandom_range(1, 300);
      span = $urandom_range(1, 6 * int'(st));
      s    = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FF00 + 32'($urandom_range(0, 255))
                                         : $urandom;
      if (s > 32'hFFFF_FFFF - span) s = 32'hFFFF_FFFF - span;
      run_sweep(s, s + span, st, 32'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                $urandom_range(6, 40), ($urandom_range(0, 2) == 0), 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
